// File: rtl/register_write_arbiter_if.sv
// Bundle of the three requester handshakes, the register-file write port
// and the status outputs of the register write arbiter.
interface register_write_arbiter_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 3
);
    logic                  alu_req;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_grant;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_grant;

    logic                  ptr_req;
    logic [ADDR_WIDTH-1:0] ptr_addr;
    logic [DATA_WIDTH-1:0] ptr_data;
    logic                  ptr_grant;

    logic                  gpr_write_enable;
    logic [ADDR_WIDTH-1:0] gpr_write_addr;
    logic [DATA_WIDTH-1:0] gpr_write_data;

    logic                  same_register_flag;
    logic                  address_error;
    logic [19:0]           write_count;

    // Requester side: drives requests, observes grants and the write port.
    modport master (
        output alu_req, alu_addr, alu_data,
        output mem_req, mem_addr, mem_data,
        output ptr_req, ptr_addr, ptr_data,
        input  alu_grant, mem_grant, ptr_grant,
        input  gpr_write_enable, gpr_write_addr, gpr_write_data,
        input  same_register_flag, address_error, write_count
    );

    // Arbiter side.
    modport slave (
        input  alu_req, alu_addr, alu_data,
        input  mem_req, mem_addr, mem_data,
        input  ptr_req, ptr_addr, ptr_data,
        output alu_grant, mem_grant, ptr_grant,
        output gpr_write_enable, gpr_write_addr, gpr_write_data,
        output same_register_flag, address_error, write_count
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing the general-purpose register file write port
// between the ALU, memory-load and pointer-update requesters. The winning
// write is registered onto the port one cycle after its grant; conflicting
// targets and out-of-range addresses are flagged for the status register.
module register_write_arbiter #(
    parameter int          DATA_WIDTH       = 20,
    parameter int          NUM_REGS         = 6,
    parameter int          ADDR_WIDTH       = 3,
    // Value write_count takes at reset; nonzero only to exercise wrap-around.
    parameter logic [19:0] WRITE_COUNT_INIT = 20'h00000
) (
    input logic                    clock,
    input logic                    reset,
    register_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        RR_ALU = 2'd0,
        RR_MEM = 2'd1,
        RR_PTR = 2'd2
    } rr_e;

    // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_CMP = (ADDR_WIDTH + 1)'(NUM_REGS);

    rr_e                   rr_q;
    rr_e                   rr_nxt;
    logic [2:0]            req;
    logic [2:0]            gnt;
    logic                  gnt_any;
    logic                  addr_legal;
    logic                  same_conflict;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_p1;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;
    logic                  same_p1;
    logic                  addr_err_p1;
    logic [19:0]           write_count_q;

    // Round-robin pointer register; ALU has first priority after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= RR_ALU;
        end else begin
            rr_q <= rr_nxt;
        end
    end

    // Grant selection from the pointer, pointer advance and winner mux.
    always_comb begin
        req      = {bus.ptr_req, bus.mem_req, bus.alu_req};
        gnt      = 3'b000;
        rr_nxt   = rr_q;
        sel_addr = '0;
        sel_data = '0;

        if (!reset) begin
            case (rr_q)
                RR_ALU: begin
                    if      (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
                RR_MEM: begin
                    if      (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                default: begin
                    if      (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
            endcase
        end

        if (gnt[0]) begin
            rr_nxt   = RR_MEM;
            sel_addr = bus.alu_addr;
            sel_data = bus.alu_data;
        end else if (gnt[1]) begin
            rr_nxt   = RR_PTR;
            sel_addr = bus.mem_addr;
            sel_data = bus.mem_data;
        end else if (gnt[2]) begin
            rr_nxt   = RR_ALU;
            sel_addr = bus.ptr_addr;
            sel_data = bus.ptr_data;
        end

        gnt_any    = |gnt;
        addr_legal = ({1'b0, sel_addr} < NUM_REGS_CMP);

        // Conflict is judged on the raw requests, regardless of the winner.
        same_conflict = (bus.alu_req && bus.mem_req && (bus.alu_addr == bus.mem_addr)) ||
                        (bus.alu_req && bus.ptr_req && (bus.alu_addr == bus.ptr_addr)) ||
                        (bus.mem_req && bus.ptr_req && (bus.mem_addr == bus.ptr_addr));
    end

    assign bus.alu_grant = gnt[0];
    assign bus.mem_grant = gnt[1];
    assign bus.ptr_grant = gnt[2];

    // Register the winning write and the status pulses; illegal addresses
    // are granted but never reach the file or the write counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en_p1      <= 1'b0;
            wr_addr_p1    <= '0;
            wr_data_p1    <= '0;
            same_p1       <= 1'b0;
            addr_err_p1   <= 1'b0;
            write_count_q <= WRITE_COUNT_INIT;
        end else begin
            wr_en_p1    <= gnt_any && addr_legal;
            same_p1     <= same_conflict;
            addr_err_p1 <= gnt_any && !addr_legal;
            if (gnt_any && addr_legal) begin
                wr_addr_p1    <= sel_addr;
                wr_data_p1    <= sel_data;
                write_count_q <= write_count_q + 20'd1;
            end
        end
    end

    assign bus.gpr_write_enable   = wr_en_p1;
    assign bus.gpr_write_addr     = wr_addr_p1;
    assign bus.gpr_write_data     = wr_data_p1;
    assign bus.same_register_flag = same_p1;
    assign bus.address_error      = addr_err_p1;
    assign bus.write_count        = write_count_q;

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares the single write port of the 6-entry, 20-bit general-purpose register file among three requesters: ALU writeback, memory load return and pointer-update unit.
- Arbitrates round-robin and registers the winning write onto the file's write port.
- Also flags same-register conflicts and illegal addresses for the status register, and counts completed writes.

Parameters:
- DATA_WIDTH, 20, width of register data.
- NUM_REGS, 6, number of implemented registers; legal addresses are 0..NUM_REGS-1.
- ADDR_WIDTH, 3, width of register address fields.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- alu_req  input  1  ALU writeback request
- alu_addr  input  ADDR_WIDTH  ALU target register
- alu_data  input  DATA_WIDTH  ALU write data
- alu_grant  output  1  ALU request accepted this cycle
- mem_req / mem_addr / mem_data / mem_grant  same as alu_*, for the memory-load requester
- ptr_req / ptr_addr / ptr_data / ptr_grant  same as alu_*, for the pointer-update requester
- gpr_write_enable  output  1  write strobe to the register file
- gpr_write_addr  output  ADDR_WIDTH  register file write address
- gpr_write_data  output  DATA_WIDTH  register file write data
- same_register_flag  output  1  two or more requests targeted the same register in the previous cycle
- address_error  output  1  the previous cycle's granted address was >= NUM_REGS
- write_count  output  20  number of completed register writes

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - gpr_write_enable=0, gpr_write_addr=0, gpr_write_data=0.
  - same_register_flag=0, address_error=0, write_count=0.
  - Round-robin pointer set to ALU.
  - All grants deassert combinationally while reset is high.
- Handshake:
  - A requester raises req with addr/data valid and holds all three stable until it sees grant high on a rising edge.
  - grant is combinational from the req inputs and the pointer, high in the cycle of acceptance only.
  - The requester may drop req, or present a new request, in the following cycle.
  - Dropping req before grant is legal; the request is simply withdrawn.
- Arbitration:
  - At most one grant per cycle.
  - Priority order starts at the pointer: ALU -> MEM -> PTR -> ALU.
  - After a grant to requester i, the pointer moves to i+1 mod 3. With no grant, the pointer holds.
  - A lone requester is granted in the same cycle regardless of the pointer.
- Write port, latency 1:
  - On the edge ending a grant cycle with a legal address: gpr_write_enable=1 for one cycle, and gpr_write_addr/data take the winner's addr/data.
  - With no grant: gpr_write_enable=0, and addr/data hold their previous values.
- Illegal address (addr >= NUM_REGS):
  - Still granted, so the requester is not stalled, and the pointer still advances.
  - gpr_write_enable stays 0, write_count does not increment, and address_error pulses for 1 cycle.
- same_register_flag:
  - Registered pulse for 1 cycle after any cycle in which at least two asserted req lines carry equal addresses.
  - Independent of which request wins. Losers remain pending and are served in later cycles, in round-robin order.
- write_count:
  - Increments by 1 on every cycle in which gpr_write_enable is set.
  - 20-bit, wraps 0xFFFFF -> 0x00000 with no flag.
- Reset mid-operation:
  - An in-flight registered write is cancelled: enable is forced to 0 immediately.
  - Pending requests are not remembered; requesters must re-present them after reset deasserts.
  - The first grant after reset follows the pointer=ALU order.

Test Plan:
- Reset release; alu_req=1, addr=2, data=0x12345 -> alu_grant=1 in the same cycle; next cycle gpr_write_enable=1, addr=2, data=0x12345, write_count=1.
- All three req held continuously with addrs 0/1/3 -> grants ALU, MEM, PTR, ALU… on successive cycles; write_count=4 after 4 writes.
- alu_req addr=4 and mem_req addr=4 in the same cycle -> ALU granted; next cycle same_register_flag=1 for one cycle; MEM granted in the following cycle, its write to reg 4 lands last.
- ptr_req addr=7 -> ptr_grant=1; next cycle address_error=1, gpr_write_enable=0, write_count unchanged.
- Force write_count to 0xFFFFF via 1,048,575 writes (or a preload backdoor), then one more write -> write_count=0x00000.
- Assert reset in the cycle after a grant -> gpr_write_enable=0 immediately, write_count=0; after release, with ptr and alu both requesting -> ALU granted first.
